// File: rtl/fifo_pkg.sv
// Gray/binary pointer helpers shared by the write- and read-side FIFO controllers.
// Functions work on a fixed wide vector. Callers zero-extend narrower pointers and keep
// the low bits of the result. Zero-extension does not change the low bits of either mapping.
package fifo_pkg;

  localparam int unsigned PtrMaxW = 16;

  typedef logic [PtrMaxW-1:0] ptr_wide_t;

  function automatic ptr_wide_t bin2gray(input ptr_wide_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_wide_t gray2bin(input ptr_wide_t g);
    ptr_wide_t b;
    b[PtrMaxW-1] = g[PtrMaxW-1];
    for (int i = PtrMaxW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_w_ctrl.sv
// Write-domain pointer/flag controller of the asynchronous FIFO. Owns the binary write
// pointer and publishes its registered Gray form. Derives full, almost-full, fill level
// and a sticky overflow flag from the read pointer synchronized into this domain.
module fifo_w_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned Addr_Size = 3,
  parameter int unsigned AF_Thresh = 6
) (
  input  logic                 W_CLK,
  input  logic                 W_RST,
  input  logic                 W_INC,
  input  logic                 OVF_CLR,
  input  logic [Addr_Size:0]   GR_Ptr_Syn,
  output logic [Addr_Size-1:0] W_Addr,
  output logic                 W_CLKEN,
  output logic [Addr_Size:0]   GW_Ptr,
  output logic                 FIFO_Full,
  output logic                 Almost_Full,
  output logic [Addr_Size:0]   W_Level,
  output logic                 Overflow
);

  localparam int unsigned PW = Addr_Size + 1;

  logic [PW-1:0] address_q;
  logic [PW-1:0] gw_ptr_q;
  logic [PW-1:0] level_q;
  logic          almost_full_q;
  logic          overflow_q;

  ptr_wide_t     gray_wide;
  ptr_wide_t     rbin_wide;
  logic [PW-1:0] gray_now;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] level_d;
  logic          full;
  logic          wr_en;

  // Upper bits of the wide helper results are always zero.
  logic [PtrMaxW-PW-1:0] unused_gray_hi;
  logic [PtrMaxW-PW-1:0] unused_rbin_hi;

  assign gray_wide      = bin2gray(PtrMaxW'(address_q));
  assign rbin_wide      = gray2bin(PtrMaxW'(GR_Ptr_Syn));
  assign gray_now       = gray_wide[PW-1:0];
  assign rbin           = rbin_wide[PW-1:0];
  assign unused_gray_hi = gray_wide[PtrMaxW-1:PW];
  assign unused_rbin_hi = rbin_wide[PtrMaxW-1:PW];

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~GR_Ptr_Syn[Addr_Size:Addr_Size-1], GR_Ptr_Syn[Addr_Size-2:0]};
  assign full     = (gray_now == full_cmp);

  // Suppressed during reset so a held write request cannot strobe the memory.
  assign wr_en   = W_INC & ~full & ~W_RST;

  // Uses the pre-increment address. The read pointer is stale, so this level never
  // under-reports the fill.
  assign level_d = address_q - rbin;

  assign W_Addr      = address_q[Addr_Size-1:0];
  assign W_CLKEN     = wr_en;
  assign GW_Ptr      = gw_ptr_q;
  assign FIFO_Full   = full;
  assign Almost_Full = almost_full_q;
  assign W_Level     = level_q;
  assign Overflow    = overflow_q;

  // Write pointer, its Gray copy and the registered level flags.
  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      address_q     <= '0;
      gw_ptr_q      <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
    end else begin
      if (wr_en) begin
        address_q <= address_q + 1'b1;
      end
      gw_ptr_q      <= gray_now;
      level_q       <= level_d;
      almost_full_q <= (level_d >= PW'(AF_Thresh));
    end
  end

  // Sticky overflow: a new overflow event wins over a same-cycle clear.
  always_ff @(posedge W_CLK) begin
    if (W_RST) begin
      overflow_q <= 1'b0;
    end else if (W_INC && full) begin
      overflow_q <= 1'b1;
    end else if (OVF_CLR) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_w_ctrl.sv
// Directed bench for fifo_w_ctrl with Addr_Size=3, AF_Thresh=6.
module tb_fifo_w_ctrl;

  logic       clk;
  logic       rst;
  logic       inc;
  logic       ovf_clr;
  logic [3:0] gr_ptr;
  logic [2:0] w_addr;
  logic       w_clken;
  logic [3:0] gw_ptr;
  logic       full;
  logic       almost_full;
  logic [3:0] w_level;
  logic       overflow;

  int checks;
  int errors;

  fifo_w_ctrl #(
    .Addr_Size(3),
    .AF_Thresh(6)
  ) dut (
    .W_CLK      (clk),
    .W_RST      (rst),
    .W_INC      (inc),
    .OVF_CLR    (ovf_clr),
    .GR_Ptr_Syn (gr_ptr),
    .W_Addr     (w_addr),
    .W_CLKEN    (w_clken),
    .GW_Ptr     (gw_ptr),
    .FIFO_Full  (full),
    .Almost_Full(almost_full),
    .W_Level    (w_level),
    .Overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] w;
    logic [3:0] r;
    logic [3:0] gw_prev;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    inc     = 1'b1;
    ovf_clr = 1'b0;
    gr_ptr  = 4'd0;

    // 1 Reset with a write request held.
    #1;
    chk("rst_clken_pre", 32'(w_clken), 32'd0);
    tick();
    chk("rst_clken", 32'(w_clken), 32'd0);
    tick();
    chk("rst_addr", 32'(w_addr), 32'd0);
    chk("rst_gw", 32'(gw_ptr), 32'd0);
    chk("rst_level", 32'(w_level), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    inc = 1'b0;
    #1;
    rst = 1'b0;
    tick();

    // 2 Fill eight entries.
    for (int i = 0; i < 8; i++) begin
      inc = 1'b1;
      #1;
      chk("fill_addr", 32'(w_addr), 32'(i));
      chk("fill_clken", 32'(w_clken), 32'd1);
      chk("fill_notfull", 32'(full), 32'd0);
      tick();
      chk("fill_level", 32'(w_level), 32'(i));
      chk("fill_af", 32'(almost_full), (i >= 6) ? 32'd1 : 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_addr_wrap", 32'(w_addr), 32'd0);
    chk("fill_gw_lag", 32'(gw_ptr), 32'b0100);
    chk("full_clken", 32'(w_clken), 32'd0);
    inc = 1'b0;
    tick();
    chk("fill_gw", 32'(gw_ptr), 32'b1100);
    chk("fill_level8", 32'(w_level), 32'd8);
    chk("fill_af8", 32'(almost_full), 32'd1);

    // 3 Overflow set, clear, and set-beats-clear.
    inc = 1'b1;
    #1;
    chk("ovf_clken", 32'(w_clken), 32'd0);
    tick();
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_addr_hold", 32'(w_addr), 32'd0);
    chk("ovf_gw_hold", 32'(gw_ptr), 32'b1100);
    inc     = 1'b0;
    ovf_clr = 1'b1;
    tick();
    chk("ovf_clr", 32'(overflow), 32'd0);
    inc = 1'b1;
    tick();
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    inc     = 1'b0;
    ovf_clr = 1'b0;

    // 4 Drain release and refill.
    gr_ptr = 4'b0001;
    #1;
    chk("drain_full_drop", 32'(full), 32'd0);
    tick();
    chk("drain_level", 32'(w_level), 32'd7);
    inc = 1'b1;
    #1;
    chk("refill_clken", 32'(w_clken), 32'd1);
    tick();
    inc = 1'b0;
    chk("refill_full", 32'(full), 32'd1);
    chk("refill_addr", 32'(w_addr), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(overflow), 32'd0);

    // 5 Wrap: reader and writer advance together across the pointer wrap.
    w = 4'd9;
    r = 4'd1;
    for (int i = 0; i < 20; i++) begin
      gw_prev = gw_ptr;
      r       = r + 4'd1;
      gr_ptr  = gray(r);
      inc     = 1'b1;
      #1;
      chk("wrap_clken", 32'(w_clken), 32'd1);
      tick();
      w   = w + 4'd1;
      inc = 1'b0;
      tick();
      chk("wrap_gw", 32'(gw_ptr), 32'(gray(w)));
      chk("wrap_gw_1bit", 32'($countones(gw_ptr ^ gw_prev)), 32'd1);
      chk("wrap_level", 32'(w_level), 32'(4'(w - r)));
      chk("wrap_level_rng", (w_level <= 4'd8) ? 32'd1 : 32'd0, 32'd1);
      chk("wrap_full", 32'(full), 32'd1);
    end

    // 6 Mid-operation reset at level 5 with overflow set.
    inc = 1'b1;
    tick();
    inc = 1'b0;
    chk("pre_rst_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 3; i++) begin
      r      = r + 4'd1;
      gr_ptr = gray(r);
      tick();
    end
    chk("pre_rst_level", 32'(w_level), 32'd5);
    chk("pre_rst_af", 32'(almost_full), 32'd0);
    rst    = 1'b1;
    gr_ptr = 4'd0;
    tick();
    rst = 1'b0;
    chk("mrst_addr", 32'(w_addr), 32'd0);
    chk("mrst_gw", 32'(gw_ptr), 32'd0);
    chk("mrst_level", 32'(w_level), 32'd0);
    chk("mrst_af", 32'(almost_full), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_full", 32'(full), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
